// File: rtl/vending_machine_change.sv
// vending_machine_change: coin-credit vending FSM with dispense, change pulses and refund; VEND_TIMEOUT_EN adds idle auto-refund
module vending_machine_change #(
    parameter int                       NUM_COINS       = 3,
    parameter logic [8*NUM_COINS-1:0]   COIN_VALS       = {8'd15, 8'd10, 8'd5},
    parameter int                       PRICE           = 15,
    parameter int                       CREDIT_W        = 7,
    parameter int                       CHANGE_UNIT     = 5,
    parameter int                       DEBOUNCE_CYCLES = 1_000_000,
    parameter int                       DISPENSE_CYCLES = 200_000_000,
    parameter int                       CHANGE_GAP      = 50_000_000,
    parameter int                       TIMEOUT_CYCLES  = 1_000_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_COINS-1:0]  coin_in,
    input  logic                  cancel,
    output logic                  newspaper,
    output logic                  change_pulse,
    output logic                  coin_reject,
    output logic                  busy,
    output logic [CREDIT_W-1:0]   credit
);
    localparam int NI = NUM_COINS + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2((DISPENSE_CYCLES > CHANGE_GAP ? DISPENSE_CYCLES : CHANGE_GAP) + 1);
    localparam int SW = CREDIT_W + 8 + $clog2(NUM_COINS + 1);
    localparam logic [CREDIT_W-1:0] CMAX = '1;
    localparam logic [CREDIT_W-1:0] P    = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] U    = CREDIT_W'(CHANGE_UNIT);

    typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE, REFUND} state_t;

    state_t                state_q, state_d;
    logic [NI-1:0]         sync1_q, sync2_q, stab_q, stab_d, prev_q, edg;
    logic [DW-1:0]         db_cnt_q [NI];
    logic [DW-1:0]         db_cnt_d [NI];
    logic [TW-1:0]         tmr_q, tmr_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d, credit_sat;
    logic [SW-1:0]         sum_w;
    logic [NUM_COINS-1:0]  coin_edg;
`ifdef VEND_TIMEOUT_EN
    localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
    logic [OW-1:0]         to_q, to_d;
`endif

    assign edg          = stab_q & ~prev_q;
    assign coin_edg     = edg[NUM_COINS-1:0];
    assign newspaper    = (state_q == DISPENSE);
    assign busy         = (state_q != IDLE);
    assign coin_reject  = busy && (|coin_edg);
    assign change_pulse = (state_q == CHANGE || state_q == REFUND) && credit_q >= U && tmr_q == '0;
    assign credit       = credit_q;

    // debounce: a synchronized level must differ from the stable level for DEBOUNCE_CYCLES cycles to be taken
    always_comb begin
        stab_d = stab_q;
        for (int k = 0; k < NI; k++) begin
            db_cnt_d[k] = '0;
            if (sync2_q[k] != stab_q[k]) begin
                if (db_cnt_q[k] == DW'(DEBOUNCE_CYCLES - 1)) stab_d[k] = sync2_q[k];
                else db_cnt_d[k] = db_cnt_q[k] + 1'b1;
            end
        end
    end

    // credit plus all coin edges of this cycle, clamped at the register maximum
    always_comb begin
        sum_w = SW'(credit_q);
        for (int k = 0; k < NUM_COINS; k++)
            sum_w = coin_edg[k] ? sum_w + SW'(COIN_VALS[8*k +: 8]) : sum_w;
        credit_sat = (sum_w > SW'(CMAX)) ? CMAX : sum_w[CREDIT_W-1:0];
    end

    // next state, credit and shared dispense/gap timer
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        tmr_d    = '0;
`ifdef VEND_TIMEOUT_EN
        to_d     = '0;
`endif
        case (state_q)
            IDLE: begin
                credit_d = credit_sat;
                if (edg[NUM_COINS] && credit_q != '0) begin
                    credit_d = credit_q;
                    state_d  = REFUND;
                end else if (credit_q >= P) begin
                    credit_d = credit_sat - P;
                    state_d  = DISPENSE;
                end
`ifdef VEND_TIMEOUT_EN
                else if (credit_q != '0 && !(|coin_edg)) begin
                    if (to_q == OW'(TIMEOUT_CYCLES - 1)) state_d = REFUND;
                    else to_d = to_q + 1'b1;
                end
`endif
            end
            DISPENSE: begin
                if (tmr_q == TW'(DISPENSE_CYCLES - 1)) begin
                    state_d  = (credit_q >= U) ? CHANGE : IDLE;
                    credit_d = (credit_q >= U) ? credit_q : '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            CHANGE, REFUND: begin
                if (credit_q < U) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end else begin
                    tmr_d    = (tmr_q == TW'(CHANGE_GAP - 1)) ? '0 : tmr_q + 1'b1;
                    credit_d = (tmr_q == '0) ? credit_q - U : credit_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // registers with synchronous active-low reset, including synchronizers and debouncers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            tmr_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            stab_q   <= '0;
            prev_q   <= '0;
            for (int k = 0; k < NI; k++) db_cnt_q[k] <= '0;
`ifdef VEND_TIMEOUT_EN
            to_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            tmr_q    <= tmr_d;
            sync1_q  <= {cancel, coin_in};
            sync2_q  <= sync1_q;
            stab_q   <= stab_d;
            prev_q   <= stab_q;
            for (int k = 0; k < NI; k++) db_cnt_q[k] <= db_cnt_d[k];
`ifdef VEND_TIMEOUT_EN
            to_q     <= to_d;
`endif
        end
    end
endmodule

// File: tb/tb_vending_machine_change.sv
// tb_vending_machine_change: vector table, hand sequences and random actions against a credit-level model
module tb_vending_machine_change;
    logic       clk = 0, reset = 0, cancel = 0;
    logic [2:0] coin_in = '0;
    logic       newspaper, change_pulse, coin_reject, busy;
    logic [6:0] credit;

    always #5 clk = ~clk;

    vending_machine_change #(
        .DEBOUNCE_CYCLES(4), .DISPENSE_CYCLES(10), .CHANGE_GAP(3), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .reset(reset), .coin_in(coin_in), .cancel(cancel),
        .newspaper(newspaper), .change_pulse(change_pulse), .coin_reject(coin_reject),
        .busy(busy), .credit(credit)
    );

    int checks = 0, failures = 0;
    int cyc = 0, np_cnt = 0, pulse_cnt = 0, rej_cnt = 0, gap_bad = 0, last_pulse = -100;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        np_cnt  += int'(newspaper);
        rej_cnt += int'(coin_reject);
        if (change_pulse) begin
            pulse_cnt++;
            if (cyc - last_pulse < 10 && cyc - last_pulse != 3) gap_bad++;
            last_pulse = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] m, input logic c);
        coin_in = m;
        cancel  = c;
        tick(10);
        coin_in = '0;
        cancel  = 0;
        tick(10);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick(1);
            n++;
        end
        chk("idle_reached", int'(busy), 0);
    endtask

    task automatic act(input string nm, input logic [2:0] m, input logic c,
                       input int e_credit, input int e_np, input int e_p);
        int b_np, b_p;
        b_np = np_cnt;
        b_p  = pulse_cnt;
        press(m, c);
        wait_idle();
        tick(2);
        chk({nm, "_credit"}, int'(credit), e_credit);
        chk({nm, "_np"}, np_cnt - b_np, e_np);
        chk({nm, "_pulses"}, pulse_cnt - b_p, e_p);
    endtask

    typedef struct {
        logic [2:0] m;
        logic       c;
        int         e_credit;
        int         e_np;
        int         e_p;
    } vec_t;

    vec_t vecs[10];

    function automatic int coin_sum(input logic [2:0] m);
        return (m[0] ? 5 : 0) + (m[1] ? 10 : 0) + (m[2] ? 15 : 0);
    endfunction

    initial begin
        int b_p, b_r, b_np, n, mcredit, e_np, e_p;
        logic [2:0] m;
        logic c;
        vecs[0] = '{3'b001, 0, 5, 0, 0};
        vecs[1] = '{3'b010, 0, 0, 10, 0};
        vecs[2] = '{3'b010, 0, 10, 0, 0};
        vecs[3] = '{3'b100, 0, 0, 10, 2};
        vecs[4] = '{3'b011, 0, 0, 10, 0};
        vecs[5] = '{3'b010, 0, 10, 0, 0};
        vecs[6] = '{3'b000, 1, 0, 0, 2};
        vecs[7] = '{3'b000, 1, 0, 0, 0};
        vecs[8] = '{3'b100, 0, 0, 10, 0};
        vecs[9] = '{3'b111, 0, 0, 10, 3};

        tick(3);
        chk("rst_newspaper", int'(newspaper), 0);
        chk("rst_pulse", int'(change_pulse), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_credit", int'(credit), 0);
        reset = 1;
        tick(2);

        for (int i = 0; i < 10; i++)
            act($sformatf("vec%0d", i), vecs[i].m, vecs[i].c, vecs[i].e_credit, vecs[i].e_np, vecs[i].e_p);
        chk("pulse_gap", gap_bad, 0);

        b_r = rej_cnt; b_np = np_cnt; b_p = pulse_cnt;
        coin_in = 3'b100;
        n = 0;
        while (!newspaper && n < 50) begin tick(1); n++; end
        chk("dispense_seen", int'(newspaper), 1);
        coin_in = 3'b101;
        tick(10);
        coin_in = '0;
        tick(10);
        wait_idle();
        tick(2);
        chk("reject_count", rej_cnt - b_r, 1);
        chk("reject_np", np_cnt - b_np, 10);
        chk("reject_credit", int'(credit), 0);
        chk("reject_pulses", pulse_cnt - b_p, 0);

        press(3'b010, 0);
        coin_in = 3'b100;
        tick(10);
        coin_in = '0;
        n = 0;
        while (!change_pulse && n < 60) begin tick(1); n++; end
        chk("first_pulse_seen", int'(change_pulse), 1);
        reset = 0;
        tick(1);
        chk("rstmid_newspaper", int'(newspaper), 0);
        chk("rstmid_pulse", int'(change_pulse), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_credit", int'(credit), 0);
        chk("rstmid_reject", int'(coin_reject), 0);
        reset = 1;
        b_p = pulse_cnt;
        tick(20);
        chk("rstmid_no_pulses", pulse_cnt - b_p, 0);
        chk("rstmid_credit_after", int'(credit), 0);

        b_p = pulse_cnt;
        coin_in = 3'b001;
        tick(10);
        coin_in = '0;
        tick(80);
`ifdef VEND_TIMEOUT_EN
        chk("timeout_credit", int'(credit), 0);
        chk("timeout_pulses", pulse_cnt - b_p, 1);
`else
        chk("hold_credit", int'(credit), 5);
        chk("hold_pulses", pulse_cnt - b_p, 0);
        act("clear", 3'b000, 1, 0, 0, 1);
`endif

        mcredit = 0;
        for (int i = 0; i < 25; i++) begin
            m = 3'($urandom_range(0, 7));
            c = ($urandom_range(0, 3) == 0) || (m == 3'b000);
            e_np = 0;
            e_p  = 0;
            if (c && mcredit > 0) begin
                e_p = mcredit / 5;
                mcredit = 0;
            end else begin
                mcredit = mcredit + coin_sum(m);
                if (mcredit > 127) mcredit = 127;
                if (mcredit >= 15) begin
                    e_np = 10;
                    e_p  = (mcredit - 15) / 5;
                    mcredit = 0;
                end
            end
            act($sformatf("rnd%0d", i), m, c, mcredit, e_np, e_p);
        end
        chk("pulse_gap_final", gap_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
